// File: rtl/modulo_n_down_counter.sv
// Modulo-N down counter: counts N-1 down to 0, then wraps back to N-1.
// It has a synchronous preload with range check and a saturating wrap counter.
// In a cascade, tc drives the en input of the next (higher) stage.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable, one decrement per edge while high
//   load      in   synchronous preload strobe, has priority over en
//   load_val  in   [WIDTH]  preload value
//   count     out  [WIDTH]  current count (registered)
//   tc        out  terminal count, combinational: en && count == 0
//   load_err  out  one-cycle pulse, the preload value was out of range (registered)
//   wraps     out  [WRAP_W] saturating count of 0 -> N-1 wraps (registered)
module modulo_n_down_counter #(
  parameter  int unsigned N      = 10,
  parameter  int unsigned WRAP_W = 8,
  localparam int unsigned WIDTH  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              load_err,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH-1:0]  CNT_MAX  = WIDTH'(N - 1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [WIDTH-1:0]  r_count;
  logic              r_load_err;
  logic [WRAP_W-1:0] r_wraps;

  logic [WIDTH-1:0]  w_count_nxt;
  logic              w_load_err_nxt;
  logic [WRAP_W-1:0] w_wraps_nxt;
  logic              w_at_zero;

  assign w_at_zero = (r_count == '0);

  // Next-state: load beats en; out-of-range loads clamp to N-1 and flag.
  always_comb begin
    w_count_nxt    = r_count;
    w_wraps_nxt    = r_wraps;
    w_load_err_nxt = 1'b0;
    if (load) begin
      if (load_val > CNT_MAX) begin
        w_count_nxt    = CNT_MAX;
        w_load_err_nxt = 1'b1;
      end else begin
        w_count_nxt = load_val;
      end
    end else if (en) begin
      if (w_at_zero) begin
        w_count_nxt = CNT_MAX;
        if (r_wraps != WRAP_MAX) begin
          w_wraps_nxt = r_wraps + WRAP_W'(1);
        end
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= CNT_MAX;
      r_load_err <= 1'b0;
      r_wraps    <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_load_err <= w_load_err_nxt;
      r_wraps    <= w_wraps_nxt;
    end
  end

  assign count    = r_count;
  assign load_err = r_load_err;
  assign wraps    = r_wraps;
  // Combinational so a downstream stage decrements on the same edge as the wrap.
  assign tc       = en && w_at_zero;

endmodule

// File: tb/tb_modulo_n_down_counter.sv
// Directed bench for modulo_n_down_counter: main N=10 instance, WRAP_W=2
// saturation instance, two-stage cascade and an N=1 instance.
module tb_modulo_n_down_counter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Main instance (N=10, WRAP_W=8)
  logic       en_m, load_m, tc_m, lerr_m;
  logic [3:0] lval_m, cnt_m;
  logic [7:0] wr_m;
  modulo_n_down_counter #(.N(10), .WRAP_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en_m), .load(load_m), .load_val(lval_m),
    .count(cnt_m), .tc(tc_m), .load_err(lerr_m), .wraps(wr_m));

  // Saturation instance (N=10, WRAP_W=2)
  logic       en_s, tc_s, lerr_s;
  logic [3:0] cnt_s;
  logic [1:0] wr_s;
  modulo_n_down_counter #(.N(10), .WRAP_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .load(1'b0), .load_val(4'd0),
    .count(cnt_s), .tc(tc_s), .load_err(lerr_s), .wraps(wr_s));

  // Cascade: stage2.en = stage1.tc
  logic       en_c, tc_c1, tc_c2, lerr_c1, lerr_c2;
  logic [3:0] cnt_c1, cnt_c2;
  logic [7:0] wr_c1, wr_c2;
  modulo_n_down_counter #(.N(10), .WRAP_W(8)) u_c1 (
    .clk(clk), .rst_n(rst_n), .en(en_c), .load(1'b0), .load_val(4'd0),
    .count(cnt_c1), .tc(tc_c1), .load_err(lerr_c1), .wraps(wr_c1));
  modulo_n_down_counter #(.N(10), .WRAP_W(8)) u_c2 (
    .clk(clk), .rst_n(rst_n), .en(tc_c1), .load(1'b0), .load_val(4'd0),
    .count(cnt_c2), .tc(tc_c2), .load_err(lerr_c2), .wraps(wr_c2));

  // N=1 instance
  logic       en_1, load_1, tc_1, lerr_1;
  logic [0:0] lval_1, cnt_1;
  logic [7:0] wr_1;
  modulo_n_down_counter #(.N(1), .WRAP_W(8)) u_one (
    .clk(clk), .rst_n(rst_n), .en(en_1), .load(load_1), .load_val(lval_1),
    .count(cnt_1), .tc(tc_1), .load_err(lerr_1), .wraps(wr_1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_m = 0; load_m = 0; lval_m = 0;
    en_s = 0; en_c = 0;
    en_1 = 0; load_1 = 0; lval_1 = 0;

    // Reset held for two edges
    step(); step();
    chk("rst_count", 32'(cnt_m), 9);
    chk("rst_wraps", 32'(wr_m), 0);
    chk("rst_lerr", 32'(lerr_m), 0);
    chk("rst_tc", 32'(tc_m), 0);
    rst_n = 1'b1;

    // Down-count through 20 states: 9..0, 9..0
    en_m = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("cnt_seq", 32'(cnt_m), 32'(9 - (i % 10)));
      chk("tc_seq", 32'(tc_m), 32'((i % 10) == 9));
      chk("wraps_seq", 32'(wr_m), 32'(i / 10));
      if (i < 19) step();
    end

    // Enable gating at count 0
    en_m = 1'b0;
    #1;
    chk("gate_tc", 32'(tc_m), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gate_hold", 32'(cnt_m), 0);
      chk("gate_tc_hold", 32'(tc_m), 0);
    end
    en_m = 1'b1;
    #1;
    chk("regate_tc", 32'(tc_m), 1);
    step();
    chk("regate_cnt", 32'(cnt_m), 9);
    chk("regate_wraps", 32'(wr_m), 2);

    // Asynchronous reset between edges at count 4
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_cnt", 32'(cnt_m), 4);
    en_m = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(cnt_m), 9);
    chk("async_rst_wraps", 32'(wr_m), 0);
    #1;
    rst_n = 1'b1;
    step();

    // Preloads
    load_m = 1'b1; lval_m = 4'd3;
    step();
    chk("load3_cnt", 32'(cnt_m), 3);
    chk("load3_err", 32'(lerr_m), 0);
    lval_m = 4'd12;
    step();
    chk("load12_cnt", 32'(cnt_m), 9);
    chk("load12_err", 32'(lerr_m), 1);
    lval_m = 4'd9;
    step();
    chk("load9_cnt", 32'(cnt_m), 9);
    chk("load9_err", 32'(lerr_m), 0);
    load_m = 1'b0;
    en_m = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("to_zero", 32'(cnt_m), 0);
    chk("to_zero_wraps", 32'(wr_m), 0);
    load_m = 1'b1; lval_m = 4'd5;
    #1;
    chk("load_en_tc", 32'(tc_m), 1);
    step();
    chk("load_en_cnt", 32'(cnt_m), 5);
    chk("load_en_wraps", 32'(wr_m), 0);
    load_m = 1'b0; en_m = 1'b0;

    // Saturation with WRAP_W=2 (wraps at edges 10,20,30,...)
    en_s = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (i == 25) chk("sat_25", 32'(wr_s), 2);
      if (i == 35) chk("sat_35", 32'(wr_s), 3);
    end
    chk("sat_50", 32'(wr_s), 3);
    en_s = 1'b0;

    // Cascade: combined value 99 down to 0, then 99
    en_c = 1'b1;
    #1;
    for (int k = 0; k <= 100; k++) begin
      chk("cascade", 32'(cnt_c2) * 10 + 32'(cnt_c1), 32'((99 - (k % 100))));
      if (k < 100) step();
    end
    en_c = 1'b0;

    // N=1
    #1;
    chk("n1_cnt", 32'(cnt_1), 0);
    chk("n1_tc_off", 32'(tc_1), 0);
    en_1 = 1'b1;
    #1;
    chk("n1_tc_on", 32'(tc_1), 1);
    step();
    chk("n1_wraps1", 32'(wr_1), 1);
    step();
    chk("n1_wraps2", 32'(wr_1), 2);
    chk("n1_cnt2", 32'(cnt_1), 0);
    load_1 = 1'b1; lval_1 = 1'b1;
    step();
    chk("n1_lerr", 32'(lerr_1), 1);
    chk("n1_load_cnt", 32'(cnt_1), 0);
    chk("n1_load_wraps", 32'(wr_1), 2);
    load_1 = 1'b0;
    step();
    chk("n1_lerr_clr", 32'(lerr_1), 0);
    chk("n1_wraps3", 32'(wr_1), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
